// File: rtl/des_pkg.sv
// DES constants: permutation tables in FIPS 46 numbering, S-boxes, key
// rotation amounts, FSM state type and a table-driven bit permutation.
package des_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } des_state_e;

    // Entries are DES bit numbers (1 = MSB of the source field); unused
    // trailing entries of shorter tables are zero.
    typedef logic [6:0] perm_tbl_t [64];
    typedef logic [3:0] sbox_t [8][64];

    localparam perm_tbl_t IP = '{
        58, 50, 42, 34, 26, 18, 10,  2, 60, 52, 44, 36, 28, 20, 12,  4,
        62, 54, 46, 38, 30, 22, 14,  6, 64, 56, 48, 40, 32, 24, 16,  8,
        57, 49, 41, 33, 25, 17,  9,  1, 59, 51, 43, 35, 27, 19, 11,  3,
        61, 53, 45, 37, 29, 21, 13,  5, 63, 55, 47, 39, 31, 23, 15,  7
    };

    localparam perm_tbl_t IP_INV = '{
        40,  8, 48, 16, 56, 24, 64, 32, 39,  7, 47, 15, 55, 23, 63, 31,
        38,  6, 46, 14, 54, 22, 62, 30, 37,  5, 45, 13, 53, 21, 61, 29,
        36,  4, 44, 12, 52, 20, 60, 28, 35,  3, 43, 11, 51, 19, 59, 27,
        34,  2, 42, 10, 50, 18, 58, 26, 33,  1, 41,  9, 49, 17, 57, 25
    };

    localparam perm_tbl_t E = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,  8,  9, 10, 11,
        12, 13, 12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21,
        22, 23, 24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1,
         0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0
    };

    localparam perm_tbl_t P = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25,
         0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0,
         0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0
    };

    localparam perm_tbl_t PC1 = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4,
         0,  0,  0,  0,  0,  0,  0,  0
    };

    localparam perm_tbl_t PC2 = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32,
         0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0
    };

    // Each box is stored row-major: index = row*16 + column.
    localparam sbox_t SBOX = '{
        '{14,  4, 13,  1,  2, 15, 11,  8,  3, 10,  6, 12,  5,  9,  0,  7,
           0, 15,  7,  4, 14,  2, 13,  1, 10,  6, 12, 11,  9,  5,  3,  8,
           4,  1, 14,  8, 13,  6,  2, 11, 15, 12,  9,  7,  3, 10,  5,  0,
          15, 12,  8,  2,  4,  9,  1,  7,  5, 11,  3, 14, 10,  0,  6, 13},
        '{15,  1,  8, 14,  6, 11,  3,  4,  9,  7,  2, 13, 12,  0,  5, 10,
           3, 13,  4,  7, 15,  2,  8, 14, 12,  0,  1, 10,  6,  9, 11,  5,
           0, 14,  7, 11, 10,  4, 13,  1,  5,  8, 12,  6,  9,  3,  2, 15,
          13,  8, 10,  1,  3, 15,  4,  2, 11,  6,  7, 12,  0,  5, 14,  9},
        '{10,  0,  9, 14,  6,  3, 15,  5,  1, 13, 12,  7, 11,  4,  2,  8,
          13,  7,  0,  9,  3,  4,  6, 10,  2,  8,  5, 14, 12, 11, 15,  1,
          13,  6,  4,  9,  8, 15,  3,  0, 11,  1,  2, 12,  5, 10, 14,  7,
           1, 10, 13,  0,  6,  9,  8,  7,  4, 15, 14,  3, 11,  5,  2, 12},
        '{ 7, 13, 14,  3,  0,  6,  9, 10,  1,  2,  8,  5, 11, 12,  4, 15,
          13,  8, 11,  5,  6, 15,  0,  3,  4,  7,  2, 12,  1, 10, 14,  9,
          10,  6,  9,  0, 12, 11,  7, 13, 15,  1,  3, 14,  5,  2,  8,  4,
           3, 15,  0,  6, 10,  1, 13,  8,  9,  4,  5, 11, 12,  7,  2, 14},
        '{ 2, 12,  4,  1,  7, 10, 11,  6,  8,  5,  3, 15, 13,  0, 14,  9,
          14, 11,  2, 12,  4,  7, 13,  1,  5,  0, 15, 10,  3,  9,  8,  6,
           4,  2,  1, 11, 10, 13,  7,  8, 15,  9, 12,  5,  6,  3,  0, 14,
          11,  8, 12,  7,  1, 14,  2, 13,  6, 15,  0,  9, 10,  4,  5,  3},
        '{12,  1, 10, 15,  9,  2,  6,  8,  0, 13,  3,  4, 14,  7,  5, 11,
          10, 15,  4,  2,  7, 12,  9,  5,  6,  1, 13, 14,  0, 11,  3,  8,
           9, 14, 15,  5,  2,  8, 12,  3,  7,  0,  4, 10,  1, 13, 11,  6,
           4,  3,  2, 12,  9,  5, 15, 10, 11, 14,  1,  7,  6,  0,  8, 13},
        '{ 4, 11,  2, 14, 15,  0,  8, 13,  3, 12,  9,  7,  5, 10,  6,  1,
          13,  0, 11,  7,  4,  9,  1, 10, 14,  3,  5, 12,  2, 15,  8,  6,
           1,  4, 11, 13, 12,  3,  7, 14, 10, 15,  6,  8,  0,  5,  9,  2,
           6, 11, 13,  8,  1,  4, 10,  7,  9,  5,  0, 15, 14,  2,  3, 12},
        '{13,  2,  8,  4,  6, 15, 11,  1, 10,  9,  3, 14,  5,  0, 12,  7,
           1, 15, 13,  8, 10,  3,  7,  4, 12,  5,  6, 11,  0, 14,  9,  2,
           7, 11,  4,  1,  9, 12, 14,  2,  0,  6, 10, 13, 15,  3,  5,  8,
           2,  1, 14,  7,  4, 10,  8, 13, 15, 12,  9,  0,  3,  5,  6, 11}
    };

    localparam logic [1:0] SHIFT [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    // Source field is right-aligned in din with DES bit 1 at din[n_in-1];
    // the result is right-aligned with output bit 1 at res[n_out-1].
    function automatic logic [63:0] permute(input perm_tbl_t tbl, input int unsigned n_in,
                                            input int unsigned n_out, input logic [63:0] din);
        logic [63:0] res;
        logic [5:0]  src;
        logic [5:0]  dst;
        res = '0;
        for (int unsigned i = 0; i < 64; i++) begin
            if (i < n_out) begin
                src      = 6'(n_in - 32'(tbl[6'(i)]));
                dst      = 6'(n_out - 1 - i);
                res[dst] = din[src];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/des_round.sv
// One combinational DES round: key rotation, PC-2, E, S-boxes, P, Feistel mix.
module des_round
    import des_pkg::*;
(
    input  logic [31:0] i_l,
    input  logic [31:0] i_r,
    input  logic [27:0] i_c,
    input  logic [27:0] i_d,
    input  logic [3:0]  i_round,
    input  logic        i_decrypt,
    output logic [31:0] o_l,
    output logic [31:0] o_r,
    output logic [27:0] o_c,
    output logic [27:0] o_d
);

    logic [1:0]  w_shift;
    logic [27:0] w_c;
    logic [27:0] w_d;
    logic [47:0] w_k;
    logic [47:0] w_e;
    logic [47:0] w_x;
    logic [31:0] w_s;
    logic [31:0] w_f;

    // Rotation amount; decrypt skips the rotation before its first round so K16 comes first.
    always_comb begin
        w_shift = SHIFT[i_round];
        if (i_decrypt && (i_round == 4'd0)) begin
            w_shift = 2'd0;
        end
    end

    // Rotate C and D left for encrypt, right for decrypt.
    always_comb begin
        w_c = i_c;
        w_d = i_d;
        if (i_decrypt) begin
            case (w_shift)
                2'd1: begin w_c = {i_c[0], i_c[27:1]};   w_d = {i_d[0], i_d[27:1]};   end
                2'd2: begin w_c = {i_c[1:0], i_c[27:2]}; w_d = {i_d[1:0], i_d[27:2]}; end
                default: ;
            endcase
        end else begin
            case (w_shift)
                2'd1: begin w_c = {i_c[26:0], i_c[27]};    w_d = {i_d[26:0], i_d[27]};    end
                2'd2: begin w_c = {i_c[25:0], i_c[27:26]}; w_d = {i_d[25:0], i_d[27:26]}; end
                default: ;
            endcase
        end
    end

    assign w_k = 48'(permute(PC2, 56, 48, {8'h00, w_c, w_d}));
    assign w_e = 48'(permute(E, 32, 48, {32'h0, i_r}));
    assign w_x = w_e ^ w_k;

    // Outer bits of each 6-bit group pick the row, inner four the column.
    for (genvar s = 0; s < 8; s++) begin : g_sbox
        logic [5:0] w_chunk;
        assign w_chunk = w_x[47 - 6*s -: 6];
        assign w_s[31 - 4*s -: 4] = SBOX[s][{w_chunk[5], w_chunk[0], w_chunk[4:1]}];
    end

    assign w_f = 32'(permute(P, 32, 32, {32'h0, w_s}));

    assign o_l = i_r;
    assign o_r = i_l ^ w_f;
    assign o_c = w_c;
    assign o_d = w_d;

endmodule

// File: rtl/des_core.sv
// Iterative DES engine: ROUNDS_PER_CYCLE rounds per clock, valid/ready in and out.
module des_core
    import des_pkg::*;
#(
    parameter int unsigned ROUNDS_PER_CYCLE = 1
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_decrypt,
    input  logic [63:0] in_key,
    input  logic [63:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic        busy
);

    if (!((ROUNDS_PER_CYCLE == 1) || (ROUNDS_PER_CYCLE == 2) || (ROUNDS_PER_CYCLE == 4) ||
          (ROUNDS_PER_CYCLE == 8) || (ROUNDS_PER_CYCLE == 16))) begin : g_bad_rpc
        $error("des_core: ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    des_state_e  r_state;
    des_state_e  w_state_next;
    logic [31:0] r_l;
    logic [31:0] r_r;
    logic [27:0] r_c;
    logic [27:0] r_d;
    logic [4:0]  r_cnt;
    logic        r_decrypt;
    logic [63:0] r_out;

    logic        w_accept;
    logic [63:0] w_ip;
    logic [55:0] w_pc1;
    logic [4:0]  w_cnt_sum;
    logic [4:0]  w_cnt_next;
    logic        w_last;
    logic [63:0] w_final;

    logic [31:0] w_l [0:ROUNDS_PER_CYCLE];
    logic [31:0] w_r [0:ROUNDS_PER_CYCLE];
    logic [27:0] w_c [0:ROUNDS_PER_CYCLE];
    logic [27:0] w_d [0:ROUNDS_PER_CYCLE];

    assign w_accept = in_valid && in_ready;
    assign w_ip     = permute(IP, 64, 64, in_data);
    assign w_pc1    = 56'(permute(PC1, 64, 56, in_key));

    assign w_l[0] = r_l;
    assign w_r[0] = r_r;
    assign w_c[0] = r_c;
    assign w_d[0] = r_d;

    for (genvar g = 0; g < ROUNDS_PER_CYCLE; g++) begin : g_round
        des_round u_round (
            .i_l       (w_l[g]),
            .i_r       (w_r[g]),
            .i_c       (w_c[g]),
            .i_d       (w_d[g]),
            .i_round   (r_cnt[3:0] + 4'(g)),
            .i_decrypt (r_decrypt),
            .o_l       (w_l[g+1]),
            .o_r       (w_r[g+1]),
            .o_c       (w_c[g+1]),
            .o_d       (w_d[g+1])
        );
    end

    assign w_cnt_sum  = r_cnt + 5'(ROUNDS_PER_CYCLE);
    assign w_cnt_next = (w_cnt_sum > 5'd16) ? 5'd16 : w_cnt_sum;
    assign w_last     = (w_cnt_next == 5'd16);
    // Halves are swapped before the inverse permutation.
    assign w_final    = permute(IP_INV, 64, 64, {w_r[ROUNDS_PER_CYCLE], w_l[ROUNDS_PER_CYCLE]});

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_accept)  w_state_next = ROUND;
            ROUND:   if (w_last)    w_state_next = DONE;
            DONE:    if (out_ready) w_state_next = IDLE;
            default:                w_state_next = IDLE;
        endcase
    end

    // Handshake and status outputs.
    always_comb begin
        in_ready  = (r_state == IDLE) && !rst;
        out_valid = (r_state == DONE);
        busy      = (r_state != IDLE);
    end

    // Datapath: load on accept, iterate in ROUND, capture the result on the last step.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_l       <= '0;
            r_r       <= '0;
            r_c       <= '0;
            r_d       <= '0;
            r_cnt     <= '0;
            r_decrypt <= 1'b0;
            r_out     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_l       <= w_ip[63:32];
                        r_r       <= w_ip[31:0];
                        r_c       <= w_pc1[55:28];
                        r_d       <= w_pc1[27:0];
                        r_cnt     <= '0;
                        r_decrypt <= in_decrypt;
                    end
                end
                ROUND: begin
                    r_l   <= w_l[ROUNDS_PER_CYCLE];
                    r_r   <= w_r[ROUNDS_PER_CYCLE];
                    r_c   <= w_c[ROUNDS_PER_CYCLE];
                    r_d   <= w_d[ROUNDS_PER_CYCLE];
                    r_cnt <= w_cnt_next;
                    if (w_last) begin
                        r_out <= w_final;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_data = r_out;

endmodule
